axi_ram_fill: RTL and testbench

AXI4 write-only master that fills a contiguous region of an `axi_ram` with a programmed pattern. A control interface (start/base/count/pattern) launches the fill. The block splits the region into INCR bursts no longer than `MAX_BURST_LEN` that never cross a 4 KB boundary, and reports completion and write-response errors. It sits in front of the RAM's write channels for memory initialisation and scrubbing; the read channels are untouched.

---
 rtl/axi_ram_pkg.sv | 23 ++
 rtl/axi_ram_fill_len_calc.sv | 37 +++
 rtl/axi_ram_fill.sv | 216 +++++++++++++++++++++
 tb/tb_axi_ram_fill.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_pkg.sv
// Shared AXI encodings and fill-engine state for the axi_ram slice.
// Used by axi_ram_fill and its burst-length helper.
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned BOUNDARY_4K = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } fill_state_e;

endpackage

// File: rtl/axi_ram_fill_len_calc.sv
// Beats for the next burst: min of remaining words, max burst
// and words left before the 4 KB page (or RAM) boundary.
module axi_ram_fill_len_calc
  import axi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int COUNT_WIDTH   = 16,
  parameter int LEN_WIDTH     = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int STRB_WIDTH    = 4
) (
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [COUNT_WIDTH-1:0] remaining_i,
  output logic [LEN_WIDTH:0]     beats_o
);

  localparam int unsigned SHIFT = $clog2(STRB_WIDTH);
  localparam int unsigned PAGE =
    (ADDR_WIDTH > 12) ? BOUNDARY_4K : (32'd1 << ADDR_WIDTH);
  localparam int BW = LEN_WIDTH + 1;

  logic [31:0] off;
  logic [31:0] room;
  logic [31:0] rem;
  logic [31:0] lim;

  always_comb begin
    off  = 32'(addr_i) & (PAGE - 1);
    room = (PAGE - off) >> SHIFT;
    rem  = 32'(remaining_i);
    lim  = MAX_BURST_LEN;
    if (rem < lim) lim = rem;
    if (room < lim) lim = room;
    beats_o = BW'(lim);
  end

endmodule

// File: rtl/axi_ram_fill.sv
// AXI4 write-only fill master: splits a region into INCR bursts.
// Define AXI_RAM_FILL_INCR_EN to write pattern + word index.
module axi_ram_fill
  import axi_ram_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int LEN_WIDTH     = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int COUNT_WIDTH   = ADDR_WIDTH,
  parameter int FILL_ID       = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [COUNT_WIDTH-1:0] word_count_i,
  input  logic [DATA_WIDTH-1:0]  pattern_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [ID_WIDTH-1:0]    axi_awid_o,
  output logic [ADDR_WIDTH-1:0]  axi_awaddr_o,
  output logic [LEN_WIDTH-1:0]   axi_awlen_o,
  output logic [2:0]             axi_awsize_o,
  output logic [1:0]             axi_awburst_o,
  output logic [1:0]             axi_awlock_o,
  output logic [3:0]             axi_awcache_o,
  output logic [2:0]             axi_awprot_o,
  output logic [3:0]             axi_awqos_o,
  output logic                   axi_awvalid_o,
  input  logic                   axi_awready_i,
  output logic [DATA_WIDTH-1:0]  axi_wdata_o,
  output logic [STRB_WIDTH-1:0]  axi_wstrb_o,
  output logic                   axi_wlast_o,
  output logic                   axi_wvalid_o,
  input  logic                   axi_wready_i,
  input  logic [ID_WIDTH-1:0]    axi_bid_i,
  input  logic [1:0]             axi_bresp_i,
  input  logic                   axi_bvalid_i,
  output logic                   axi_bready_o
);

  localparam int unsigned SHIFT = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ADDR_WIDTH'(STRB_WIDTH - 1);

  fill_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
  logic [LEN_WIDTH-1:0]   awlen_q, awlen_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic wlast_q, wlast_d;
  logic bready_q, bready_d;
  logic err_q, err_d;
  logic done_q, done_d;

  logic [ADDR_WIDTH-1:0]  step;
  logic [ADDR_WIDTH-1:0]  calc_addr;
  logic [COUNT_WIDTH-1:0] calc_rem;
  logic [LEN_WIDTH:0]     beats;
  logic [DATA_WIDTH-1:0]  wdata_nx;
  logic                   unused_bid;

  assign unused_bid = ^axi_bid_i;

  assign step = ADDR_WIDTH'((32'(awlen_q) + 32'd1) << SHIFT);
  assign calc_addr = (state_q == ST_IDLE)
                   ? (base_addr_i & ~AMASK)
                   : (awaddr_q + step);
  assign calc_rem = (state_q == ST_IDLE) ? word_count_i : rem_q;

`ifdef AXI_RAM_FILL_INCR_EN
  assign wdata_nx = wdata_q + 1'b1;
`else
  assign wdata_nx = wdata_q;
`endif

  axi_ram_fill_len_calc #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .COUNT_WIDTH   (COUNT_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN),
    .STRB_WIDTH    (STRB_WIDTH)
  ) u_len (
    .addr_i      (calc_addr),
    .remaining_i (calc_rem),
    .beats_o     (beats)
  );

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    beat_d    = beat_q;
    rem_d     = rem_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    bready_d  = bready_q;
    err_d     = err_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          err_d    = 1'b0;
          rem_d    = word_count_i;
          wdata_d  = pattern_i;
          awaddr_d = calc_addr;
          awlen_d  = LEN_WIDTH'(beats - 1'b1);
          if (word_count_i == '0) begin
            done_d = 1'b1;
          end else begin
            awvalid_d = 1'b1;
            state_d   = ST_AW;
          end
        end
      end
      ST_AW: begin
        if (axi_awready_i) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wlast_d   = (awlen_q == '0);
          beat_d    = awlen_q;
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (wvalid_q && axi_wready_i) begin
          rem_d   = rem_q - 1'b1;
          wdata_d = wdata_nx;
          beat_d  = beat_q - 1'b1;
          if (wlast_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            state_d  = ST_B;
          end else begin
            wlast_d = (beat_q == LEN_WIDTH'(1));
          end
        end
      end
      ST_B: begin
        if (axi_bvalid_i) begin
          bready_d = 1'b0;
          err_d    = err_q | (axi_bresp_i != RESP_OKAY);
          if (rem_q == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            awaddr_d  = calc_addr;
            awlen_d   = LEN_WIDTH'(beats - 1'b1);
            awvalid_d = 1'b1;
            state_d   = ST_AW;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      beat_q    <= '0;
      rem_q     <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      beat_q    <= beat_d;
      rem_q     <= rem_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign error_o       = err_q;
  assign axi_awid_o    = ID_WIDTH'(FILL_ID);
  assign axi_awaddr_o  = awaddr_q;
  assign axi_awlen_o   = awlen_q;
  assign axi_awsize_o  = 3'(SHIFT);
  assign axi_awburst_o = BURST_INCR;
  assign axi_awlock_o  = 2'b00;
  assign axi_awcache_o = 4'b0011;
  assign axi_awprot_o  = 3'b000;
  assign axi_awqos_o   = 4'b0000;
  assign axi_awvalid_o = awvalid_q;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = '1;
  assign axi_wlast_o   = wlast_q;
  assign axi_wvalid_o  = wvalid_q;
  assign axi_bready_o  = bready_q;

endmodule

// File: tb/tb_axi_ram_fill.sv
// Directed bench for axi_ram_fill with a behavioural RAM slave.
// Honours AXI_RAM_FILL_INCR_EN for the expected write data.
module tb_axi_ram_fill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [31:0] pattern = '0;
  logic        busy_o, done_o, error_o;
  logic [7:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache, awqos;
  logic        awvalid, wvalid, wlast, bready;
  logic        awready = 1'b1;
  logic        wready = 1'b1;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;

  always #5 clk = ~clk;

  axi_ram_fill dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .base_addr_i(base_addr), .word_count_i(word_count),
    .pattern_i(pattern), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .axi_awid_o(awid), .axi_awaddr_o(awaddr),
    .axi_awlen_o(awlen), .axi_awsize_o(awsize),
    .axi_awburst_o(awburst), .axi_awlock_o(awlock),
    .axi_awcache_o(awcache), .axi_awprot_o(awprot),
    .axi_awqos_o(awqos), .axi_awvalid_o(awvalid),
    .axi_awready_i(awready), .axi_wdata_o(wdata),
    .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
    .axi_wvalid_o(wvalid), .axi_wready_i(wready),
    .axi_bid_i(8'h00), .axi_bresp_i(bresp),
    .axi_bvalid_i(bvalid), .axi_bready_o(bready)
  );

  // Slave model and protocol monitors
  logic [31:0] mem [0:16383];
  logic [15:0] aw_addr_log [0:63];
  logic [7:0]  aw_len_log [0:63];
  int n_aw = 0, nb = 0, wbeats = 0, viol = 0;
  int aw_hi = 0, busy_hi = 0, bdly = 0;
  int stall_en = 0, bdelay = 0, err_burst = -1;
  logic [15:0] cur_addr = '0;
  logic [7:0]  cur_len = '0, beat = '0;
  logic        bpend = 1'b0;
  logic        w_st = 1'b0, aw_st = 1'b0, st_last = 1'b0;
  logic [31:0] st_data = '0;
  logic [23:0] st_aw = '0;

  always @(posedge clk) begin
    wready  <= (stall_en != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
    awready <= (stall_en != 0) ? ($urandom_range(0, 1) != 0) : 1'b1;
    if (awvalid) aw_hi <= aw_hi + 1;
    if (busy_o) busy_hi <= busy_hi + 1;
    if (w_st && wvalid && (wdata !== st_data || wlast !== st_last))
      viol <= viol + 1;
    if (aw_st && awvalid && {awaddr, awlen} !== st_aw)
      viol <= viol + 1;
    w_st    <= wvalid && !wready;
    aw_st   <= awvalid && !awready;
    st_data <= wdata;
    st_last <= wlast;
    st_aw   <= {awaddr, awlen};
    if (rst) begin
      bvalid <= 1'b0;
      bpend  <= 1'b0;
      beat   <= '0;
    end else begin
      if (awvalid && awready) begin
        aw_addr_log[n_aw[5:0]] <= awaddr;
        aw_len_log[n_aw[5:0]]  <= awlen;
        n_aw     <= n_aw + 1;
        cur_addr <= awaddr;
        cur_len  <= awlen;
        beat     <= '0;
      end
      if (wvalid && wready) begin
        mem[cur_addr[15:2]] <= wdata;
        cur_addr <= cur_addr + 16'd4;
        beat     <= beat + 8'd1;
        wbeats   <= wbeats + 1;
        if (wlast !== (beat == cur_len)) viol <= viol + 1;
        if (wlast) begin
          bpend <= 1'b1;
          bdly  <= bdelay;
        end
      end
      if (bpend && !bvalid) begin
        if (bdly == 0) begin
          bvalid <= 1'b1;
          bresp  <= (nb == err_burst) ? 2'b10 : 2'b00;
          bpend  <= 1'b0;
        end else begin
          bdly <= bdly - 1;
        end
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        nb     <= nb + 1;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] p,
                                           input int k);
`ifdef AXI_RAM_FILL_INCR_EN
    return p + 32'(k);
`else
    return p + 32'(k * 0);
`endif
  endfunction

  task automatic do_start(input logic [15:0] b, input logic [15:0] c,
                          input logic [31:0] p);
    @(posedge clk); #1;
    base_addr = b; word_count = c; pattern = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output logic err);
    bit got = 0;
    err = 1'bx;
    for (int c = 0; c < 3000 && !got; c++) begin
      if (done_o) begin
        got = 1;
        err = error_o;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk({tag, "_done"}, 64'(got), 64'd1);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {62'd0, done_o, busy_o}, 64'd0);
  endtask

  task automatic chk_mem(input string tag, input logic [15:0] b,
                         input int c, input logic [31:0] p);
    for (int k = 0; k < c; k++)
      chk(tag, 64'(mem[b[15:2] + 14'(k)]), 64'(exp_word(p, k)));
  endtask

  task automatic chk_aw(input string tag, input int idx,
                        input logic [15:0] a, input logic [7:0] l);
    chk(tag, {40'd0, aw_addr_log[idx], aw_len_log[idx]}, {40'd0, a, l});
  endtask

  initial begin
    logic e;
    int a0, h0, b0, w0, dn;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {58'd0, awvalid, wvalid, bready, busy_o, done_o,
                      error_o}, 64'd0);
    chk("const_fields", {34'd0, awid, awsize, awburst, awlock, awcache,
                         awprot, awqos, wstrb},
        {34'd0, 8'h00, 3'd2, 2'b01, 2'b00, 4'b0011, 3'd0, 4'd0, 4'hF});
    rst = 1'b0;

    // single burst with start latency
    a0 = n_aw;
    do_start(16'h0000, 16'd4, 32'hA5A5A5A5);
    chk("start_lat", {40'd0, awvalid, busy_o, awaddr, awlen},
        {40'd0, 1'b1, 1'b1, 16'h0000, 8'd3});
    wait_done("single", e);
    chk("single_err", 64'(e), 64'd0);
    chk("single_naw", 64'(n_aw - a0), 64'd1);
    chk_aw("single_aw", a0, 16'h0000, 8'd3);
    chk_mem("single_mem", 16'h0000, 4, 32'hA5A5A5A5);

    // burst splitting
    a0 = n_aw;
    do_start(16'h0000, 16'd40, 32'h0BADF00D);
    wait_done("split", e);
    chk("split_naw", 64'(n_aw - a0), 64'd3);
    chk_aw("split_aw0", a0, 16'h0000, 8'd15);
    chk_aw("split_aw1", a0 + 1, 16'h0040, 8'd15);
    chk_aw("split_aw2", a0 + 2, 16'h0080, 8'd7);
    chk_mem("split_mem", 16'h0000, 40, 32'h0BADF00D);

    // 4 KB boundary with unaligned base
    a0 = n_aw;
    do_start(16'h0FFB, 16'd6, 32'h11223344);
    wait_done("bound", e);
    chk("bound_naw", 64'(n_aw - a0), 64'd2);
    chk_aw("bound_aw0", a0, 16'h0FF8, 8'd1);
    chk_aw("bound_aw1", a0 + 1, 16'h1000, 8'd3);
    chk_mem("bound_mem", 16'h0FF8, 6, 32'h11223344);

    // zero count
    h0 = aw_hi; b0 = busy_hi;
    do_start(16'h0100, 16'd0, 32'hFFFFFFFF);
    chk("zero_done", {62'd0, done_o, busy_o}, 64'd2);
    @(posedge clk); #1;
    chk("zero_pulse", 64'(done_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_awv", 64'(aw_hi - h0), 64'd0);
    chk("zero_busy", 64'(busy_hi - b0), 64'd0);

    // backpressure, B delay and error on burst 2
    a0 = n_aw;
    stall_en = 1; bdelay = 5; err_burst = nb + 1;
    do_start(16'h2000, 16'd40, 32'h12345678);
    wait_done("bp", e);
    stall_en = 0; bdelay = 0; err_burst = -1;
    chk("bp_err", 64'(e), 64'd1);
    chk("bp_naw", 64'(n_aw - a0), 64'd3);
    chk_aw("bp_aw2", a0 + 2, 16'h2080, 8'd7);
    chk_mem("bp_mem", 16'h2000, 40, 32'h12345678);
    chk("proto_viol", 64'(viol), 64'd0);
    do_start(16'h4000, 16'd2, 32'h0000FFFF);
    wait_done("clr", e);
    chk("err_cleared", 64'(e), 64'd0);
    chk_mem("clr_mem", 16'h4000, 2, 32'h0000FFFF);

    // reset during beat 3 of a 16-beat burst
    w0 = wbeats;
    do_start(16'h3000, 16'd16, 32'h55555555);
    for (int c = 0; c < 200 && wbeats < w0 + 2; c++) begin
      @(posedge clk); #1;
    end
    chk("rst_beat3", 64'(wbeats - w0), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_outs", {59'd0, awvalid, wvalid, bready, busy_o, done_o},
        64'd0);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done_o) dn++;
    end
    chk("rst_nodone", 64'(dn), 64'd0);
    do_start(16'h3000, 16'd16, 32'hDEADBEEF);
    wait_done("refill", e);
    chk("refill_err", 64'(e), 64'd0);
    chk_mem("refill_mem", 16'h3000, 16, 32'hDEADBEEF);
    chk("proto_viol_end", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
